// File: rtl/spi_cfg_pkg.sv
// Shared constants and helpers for the SPI configuration sequencer.
package spi_cfg_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_CHECK = 3'd2;
  localparam state_t ST_SHIFT = 3'd3;
  localparam state_t ST_GAP   = 3'd4;
  localparam state_t ST_DONE  = 3'd5;
  localparam state_t ST_ERR   = 3'd6;

  // Wide enough for any practical entry; callers slice to ENTRY_W.
  localparam logic [63:0] SENTINEL = '1;

  function automatic int entry_w(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

  // rw flag sits just above the addr and data fields.
  function automatic int rw_pos(input int aw, input int dw);
    return aw + dw;
  endfunction

endpackage

// File: rtl/spi_cfg_sequencer_if.sv
// Control, table and SPI pin bundle of the configuration sequencer.
interface spi_cfg_sequencer_if
  import spi_cfg_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int LUT_DEPTH = 32,
  parameter int NUM_CS    = 2
);
  localparam int IDX_W   = $clog2(LUT_DEPTH);
  localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int ENTRY_W = entry_w(ADDR_W, DATA_W);

  logic               start;
  logic [CS_W-1:0]    cs_sel;
  logic [IDX_W-1:0]   lut_index;
  logic [ENTRY_W-1:0] lut_data;
  logic               spi_sclk;
  logic [NUM_CS-1:0]  spi_csn;
  logic               spi_mosi;
  logic               spi_miso;
  logic               busy;
  logic               done;
  logic               error;
  logic [IDX_W-1:0]   err_index;
  logic [DATA_W-1:0]  rd_data;

  modport slave (
    input  start, cs_sel, lut_data, spi_miso,
    output lut_index, spi_sclk, spi_csn, spi_mosi, busy, done, error, err_index, rd_data
  );

  modport master (
    output start, cs_sel, lut_data, spi_miso,
    input  lut_index, spi_sclk, spi_csn, spi_mosi, busy, done, error, err_index, rd_data
  );

endinterface

// File: rtl/spi_cfg_sequencer_shift_engine.sv
// One SPI mode-0 frame per load: SCLK divider, MOSI shift, MISO capture, CSn timing.
module spi_shift_engine #(
  parameter int ENTRY_W = 16,
  parameter int DATA_W  = 8,
  parameter int NUM_CS  = 2,
  parameter int CS_W    = 1,
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [ENTRY_W-1:0] frame_i,
  input  logic [CS_W-1:0]    cs_i,
  input  logic               miso_i,
  output logic               sclk_o,
  output logic [NUM_CS-1:0]  csn_o,
  output logic               mosi_o,
  output logic [DATA_W-1:0]  rx_o,
  output logic               frame_done_o
);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(ENTRY_W + 1);

  logic               active_q, active_d, tail_q, tail_d, sclk_q, sclk_d;
  logic               mosi_q, mosi_d, done_q, done_d;
  logic [NUM_CS-1:0]  csn_q, csn_d;
  logic [ENTRY_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;

  always_comb begin
    active_d = active_q;
    tail_d   = tail_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    csn_d    = csn_q;
    sh_d     = sh_q;
    rx_d     = rx_q;
    div_d    = div_q;
    bit_d    = bit_q;
    done_d   = 1'b0;
    if (load_i && !active_q) begin
      active_d = 1'b1;
      tail_d   = 1'b0;
      sclk_d   = 1'b0;
      div_d    = '0;
      bit_d    = '0;
      sh_d     = frame_i;
      mosi_d   = frame_i[ENTRY_W-1];
      for (int i = 0; i < NUM_CS; i++) csn_d[i] = (CS_W'(i) != cs_i);
    end else if (active_q) begin
      if (div_q == DIV_W'(CLK_DIV - 1)) begin
        div_d = '0;
        if (tail_q) begin
          // trailing half-period elapsed: release CSn and hand back
          active_d = 1'b0;
          tail_d   = 1'b0;
          csn_d    = '1;
          mosi_d   = 1'b0;
          done_d   = 1'b1;
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[DATA_W-2:0], miso_i};
        end else begin
          sclk_d = 1'b0;
          if (bit_q == BIT_W'(ENTRY_W - 1)) begin
            tail_d = 1'b1;
          end else begin
            bit_d  = bit_q + 1'b1;
            sh_d   = {sh_q[ENTRY_W-2:0], 1'b0};
            mosi_d = sh_q[ENTRY_W-2];
          end
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      tail_q   <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
      csn_q    <= '1;
      sh_q     <= '0;
      rx_q     <= '0;
      div_q    <= '0;
      bit_q    <= '0;
    end else begin
      active_q <= active_d;
      tail_q   <= tail_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      done_q   <= done_d;
      csn_q    <= csn_d;
      sh_q     <= sh_d;
      rx_q     <= rx_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
    end
  end

  assign sclk_o       = sclk_q;
  assign csn_o        = csn_q;
  assign mosi_o       = mosi_q;
  assign rx_o         = rx_q;
  assign frame_done_o = done_q;

endmodule

// File: rtl/spi_cfg_sequencer.sv
// Table-driven SPI register configuration sequencer: FSM, indexing, readback verify.
// Build option: define CFG_READ_VERIFY_EN to compare read data against the table entry.
module spi_cfg_sequencer
  import spi_cfg_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int LUT_DEPTH = 32,
  parameter int NUM_CS    = 2,
  parameter int CLK_DIV   = 4,
  parameter int CS_GAP    = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  spi_cfg_sequencer_if.slave  bus
);
  localparam int ENTRY_W = entry_w(ADDR_W, DATA_W);
  localparam int RW_BIT  = rw_pos(ADDR_W, DATA_W);
  localparam int IDX_W   = $clog2(LUT_DEPTH);
  localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int GAP_W   = $clog2(CS_GAP + 1);
  localparam logic [ENTRY_W-1:0] SENT     = SENTINEL[ENTRY_W-1:0];
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(LUT_DEPTH - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, err_idx_q, err_idx_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic [CS_W-1:0]    cs_q, cs_d, cs_clamped;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [DATA_W-1:0]  rd_q, rd_d, rx_data;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d, mism_q, mism_d;
  logic               load, frame_done, mismatch;

  assign cs_clamped = (int'(bus.cs_sel) >= NUM_CS) ? '0 : bus.cs_sel;

`ifdef CFG_READ_VERIFY_EN
  assign mismatch = entry_q[RW_BIT] && (rx_data != entry_q[DATA_W-1:0]);
`else
  assign mismatch = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_idx_d = err_idx_q;
    entry_d   = entry_q;
    cs_d      = cs_q;
    gap_d     = gap_q;
    rd_d      = rd_q;
    busy_d    = busy_q;
    err_d     = err_q;
    mism_d    = mism_q;
    done_d    = 1'b0;
    load      = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        busy_d  = 1'b1;
        err_d   = 1'b0;
        mism_d  = 1'b0;
        idx_d   = '0;
        cs_d    = cs_clamped;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        entry_d = bus.lut_data;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (entry_q == SENT) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: if (frame_done) begin
        if (entry_q[RW_BIT]) rd_d = rx_data;
        mism_d  = mismatch;
        gap_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(CS_GAP - 1)) begin
          if (mism_q) begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
            busy_d    = 1'b0;
            state_d   = ST_ERR;
          end else if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_FETCH;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      err_idx_q <= '0;
      entry_q   <= '0;
      cs_q      <= '0;
      gap_q     <= '0;
      rd_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mism_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_idx_q <= err_idx_d;
      entry_q   <= entry_d;
      cs_q      <= cs_d;
      gap_q     <= gap_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      mism_q    <= mism_d;
    end
  end

  spi_shift_engine #(
    .ENTRY_W (ENTRY_W),
    .DATA_W  (DATA_W),
    .NUM_CS  (NUM_CS),
    .CS_W    (CS_W),
    .CLK_DIV (CLK_DIV)
  ) u_eng (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load),
    .frame_i      (entry_q),
    .cs_i         (cs_q),
    .miso_i       (bus.spi_miso),
    .sclk_o       (bus.spi_sclk),
    .csn_o        (bus.spi_csn),
    .mosi_o       (bus.spi_mosi),
    .rx_o         (rx_data),
    .frame_done_o (frame_done)
  );

  assign bus.lut_index = idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = err_q;
  assign bus.err_index = err_idx_q;
  assign bus.rd_data   = rd_q;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Directed bench for spi_cfg_sequencer: frame shape, readback, table exhaust, reset abort.
module tb_spi_cfg_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_cfg_sequencer_if #(.ADDR_W(7), .DATA_W(8), .LUT_DEPTH(4), .NUM_CS(2)) bus ();

  spi_cfg_sequencer #(
    .ADDR_W(7), .DATA_W(8), .LUT_DEPTH(4), .NUM_CS(2), .CLK_DIV(2), .CS_GAP(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] lut [4];
  assign bus.lut_data = lut[bus.lut_index];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SPI slave model and frame recorder, sampled on the falling clk edge
  logic [15:0] miso_resp = '0;
  logic [15:0] mosi_sh   = '0;
  int rise_cnt = 0, low_cyc = 0, done_cnt = 0;
  bit cs1_low = 1'b0, csn_prev = 1'b1, sclk_prev = 1'b0;
  logic [15:0] fr_mosi[$];
  int fr_len[$], fr_rise[$];

  always @(negedge clk) begin
    if (!bus.spi_csn[1]) cs1_low = 1'b1;
    if (bus.done) done_cnt++;
    if (!bus.spi_csn[0]) begin
      if (csn_prev) begin
        rise_cnt = 0;
        low_cyc  = 0;
        mosi_sh  = '0;
      end
      low_cyc++;
      if (bus.spi_sclk && !sclk_prev) begin
        mosi_sh = {mosi_sh[14:0], bus.spi_mosi};
        rise_cnt++;
      end
    end else if (!csn_prev) begin
      fr_mosi.push_back(mosi_sh);
      fr_len.push_back(low_cyc);
      fr_rise.push_back(rise_cnt);
    end
    bus.spi_miso = (rise_cnt < 16) ? miso_resp[4'(15 - rise_cnt)] : 1'b0;
    csn_prev  = bus.spi_csn[0];
    sclk_prev = bus.spi_sclk;
  end

  task automatic clr();
    fr_mosi.delete();
    fr_len.delete();
    fr_rise.delete();
    done_cnt = 0;
    cs1_low  = 1'b0;
    rise_cnt = 0;
  endtask

  task automatic pulse_start(input logic cs);
    @(posedge clk);
    #1 bus.cs_sel = cs;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.cs_sel = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(bus.busy), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start  = 1'b0;
    bus.cs_sel = 1'b0;
    lut = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    repeat (3) @(negedge clk);
    chk("rst_idx",    32'(bus.lut_index), 0);
    chk("rst_sclk",   32'(bus.spi_sclk), 0);
    chk("rst_csn",    32'(bus.spi_csn), 32'h3);
    chk("rst_mosi",   32'(bus.spi_mosi), 0);
    chk("rst_busy",   32'(bus.busy), 0);
    chk("rst_done",   32'(bus.done), 0);
    chk("rst_err",    32'(bus.error), 0);
    chk("rst_erridx", 32'(bus.err_index), 0);
    chk("rst_rd",     32'(bus.rd_data), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // two writes then sentinel; a second start with cs_sel=1 mid-walk must be ignored
    lut = '{16'h00A0, 16'h0080, 16'hFFFF, 16'hFFFF};
    clr();
    pulse_start(1'b0);
    chk("t1_busy", 32'(bus.busy), 1);
    repeat (100) @(posedge clk);
    pulse_start(1'b1);
    wait_idle("t1");
    chk("t1_frames", fr_mosi.size(), 2);
    chk("t1_mosi0",  32'(fr_mosi[0]), 32'h00A0);
    chk("t1_mosi1",  32'(fr_mosi[1]), 32'h0080);
    chk("t1_rise0",  fr_rise[0], 16);
    chk("t1_rise1",  fr_rise[1], 16);
    chk("t1_len0",   fr_len[0], 66);
    chk("t1_len1",   fr_len[1], 66);
    chk("t1_done",   done_cnt, 1);
    chk("t1_cs1",    32'(cs1_low), 0);
    chk("t1_err",    32'(bus.error), 0);
    chk("t1_idx",    32'(bus.lut_index), 2);

    // read entry, matching readback
    lut = '{16'h8355, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    miso_resp = 16'h0055;
    clr();
    pulse_start(1'b0);
    wait_idle("t2");
    chk("t2_mosi",   32'(fr_mosi[0]), 32'h8355);
    chk("t2_rd",     32'(bus.rd_data), 32'h55);
    chk("t2_err",    32'(bus.error), 0);
    chk("t2_done",   done_cnt, 1);

    // read entry, mismatching readback, followed by a write
    lut = '{16'h8355, 16'h0011, 16'hFFFF, 16'hFFFF};
    miso_resp = 16'h0054;
    clr();
    pulse_start(1'b0);
    wait_idle("t3");
    chk("t3_rd",     32'(bus.rd_data), 32'h54);
`ifdef CFG_READ_VERIFY_EN
    chk("t3_err",    32'(bus.error), 1);
    chk("t3_erridx", 32'(bus.err_index), 0);
    chk("t3_frames", fr_mosi.size(), 1);
    chk("t3_done",   done_cnt, 0);
`else
    chk("t3_err",    32'(bus.error), 0);
    chk("t3_frames", fr_mosi.size(), 2);
    chk("t3_done",   done_cnt, 1);
`endif

    // full table, no sentinel
    lut = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    miso_resp = 16'h0000;
    clr();
    pulse_start(1'b0);
    chk("t4_errclr", 32'(bus.error), 0);
    wait_idle("t4");
    chk("t4_frames", fr_mosi.size(), 4);
    chk("t4_mosi3",  32'(fr_mosi[3]), 32'h0004);
    chk("t4_idx",    32'(bus.lut_index), 3);
    chk("t4_done",   done_cnt, 1);

    // reset in the middle of the first frame, then restart
    lut = '{16'h00A0, 16'h0080, 16'hFFFF, 16'hFFFF};
    clr();
    pulse_start(1'b0);
    begin
      int n = 0;
      while (rise_cnt < 5 && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t5_midframe", 32'(bus.spi_csn), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_csn",  32'(bus.spi_csn), 32'h3);
    chk("t5_sclk", 32'(bus.spi_sclk), 0);
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_idx",  32'(bus.lut_index), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clr();
    pulse_start(1'b0);
    wait_idle("t5");
    chk("t5_frames", fr_mosi.size(), 2);
    chk("t5_mosi0",  32'(fr_mosi[0]), 32'h00A0);
    chk("t5_done",   done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
